// File: rtl/fir_tap_sequencer_pkg.sv
// rtl/fir_tap_sequencer_pkg.sv - shared widths and FSM encoding for the FIR tap sequencer
package fir_tap_sequencer_pkg;

    localparam int ADDR_W  = 8;    // sample RAM address width (256 entries)
    localparam int DATA_W  = 16;   // sample width
    localparam int GROUP_W = 4;    // samples returned per RAM read (4 banks)
    localparam int COEF_W  = 6;    // tap-group index width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fir_write_pointer.sv
// rtl/fir_write_pointer.sv - sample RAM write pointer, decimation phase counter and trigger generation
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid, in_data     : input sample stream
//   ram_data, ram_wraddress, ram_wren : registered RAM write port, one cycle after acceptance
//   trigger               : high in the same cycle as the write of the trigger sample
module fir_write_pointer
    import fir_tap_sequencer_pkg::*;
#(
    parameter int DECIM = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_wren,
    output logic              trigger
);

    localparam logic [7:0] PHASE_LAST = 8'(DECIM - 1);

    logic [ADDR_W-1:0] wptr;
    logic [7:0]        phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr          <= '0;
            phase         <= '0;
            ram_data      <= '0;
            ram_wraddress <= '0;
            ram_wren      <= 1'b0;
            trigger       <= 1'b0;
        end else begin
            ram_wren <= in_valid;
            trigger  <= 1'b0;
            if (in_valid) begin
                ram_data      <= in_data;
                ram_wraddress <= wptr;
                wptr          <= wptr + 8'd1;   // natural 8-bit wrap 255 -> 0
                if (phase == PHASE_LAST) begin
                    phase   <= '0;
                    trigger <= 1'b1;
                end else begin
                    phase <= phase + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - FIR tap-group read sequencer over a 4-bank circular sample RAM
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid, in_data     : input sample stream
//   ram_data, ram_wraddress, ram_wren : RAM write port
//   ram_rdaddress         : RAM base read address (RAM returns 4 samples one cycle later)
//   tap_valid, tap_first, tap_last, coef_addr : tap-group qualifiers aligned with RAM read data
//   busy                  : burst in progress (READ or FLUSH)
//   overrun               : sticky, a trigger was dropped because one was already pending
module fir_tap_sequencer
    import fir_tap_sequencer_pkg::*;
#(
    parameter int NTAPS = 64,
    parameter int DECIM = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic              tap_valid,
    output logic              tap_first,
    output logic              tap_last,
    output logic [COEF_W-1:0] coef_addr,
    output logic              busy,
    output logic              overrun
);

    localparam int                NGROUPS    = NTAPS / GROUP_W;
    localparam logic [COEF_W-1:0] K_LAST     = COEF_W'(NGROUPS - 1);
    localparam logic [ADDR_W-1:0] TAP_SPAN   = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W-1:0] GROUP_STEP = ADDR_W'(GROUP_W);

    seq_state_t        state, state_nx;
    logic [COEF_W-1:0] group;
    logic              trigger;
    logic [ADDR_W-1:0] trig_base;
    logic              pending, pending_nx;
    logic [ADDR_W-1:0] pend_base, pend_base_nx;
    logic              overrun_nx;
    logic              start;
    logic [ADDR_W-1:0] start_base;

    fir_write_pointer #(
        .DECIM (DECIM)
    ) u_write_pointer (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .ram_data      (ram_data),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .trigger       (trigger)
    );

    // Oldest sample of the window ending at the trigger sample; wraps mod 256.
    assign trig_base = ram_wraddress - TAP_SPAN;

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nx     = state;
        pending_nx   = pending;
        pend_base_nx = pend_base;
        overrun_nx   = overrun;
        start        = 1'b0;
        start_base   = trig_base;

        unique case (state)
            ST_IDLE: begin
                if (trigger) begin
                    start = 1'b1;
                end
            end
            ST_READ: begin
                if (group == K_LAST) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nx = ST_IDLE;
                if (pending || trigger) begin
                    start = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (start) begin
            state_nx = ST_READ;
            // A held trigger is older than one arriving now, so it goes first and
            // the new arrival takes over the one-deep pending slot.
            if (pending) begin
                start_base   = pend_base;
                pending_nx   = trigger;
                pend_base_nx = trig_base;
            end
        end else if (trigger) begin
            if (pending) begin
                overrun_nx = 1'b1;
            end else begin
                pending_nx   = 1'b1;
                pend_base_nx = trig_base;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            group         <= '0;
            ram_rdaddress <= '0;
            pending       <= 1'b0;
            pend_base     <= '0;
            overrun       <= 1'b0;
            tap_valid     <= 1'b0;
            tap_first     <= 1'b0;
            tap_last      <= 1'b0;
            coef_addr     <= '0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            pend_base <= pend_base_nx;
            overrun   <= overrun_nx;

            // Read address only moves inside READ; it holds through FLUSH and IDLE.
            if (start) begin
                group         <= '0;
                ram_rdaddress <= start_base;
            end else if (state == ST_READ && group != K_LAST) begin
                group         <= group + COEF_W'(1);
                ram_rdaddress <= ram_rdaddress + GROUP_STEP;
            end

            // Qualifiers trail the read address by one cycle to meet the RAM data.
            tap_valid <= (state == ST_READ);
            tap_first <= (state == ST_READ) && (group == '0);
            tap_last  <= (state == ST_READ) && (group == K_LAST);
            coef_addr <= (state == ST_READ) ? group : '0;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - self-checking bench for fir_tap_sequencer over three parameter sets
`timescale 1ns/1ps
module tb_fir_tap_sequencer;

    localparam int NI  = 3;
    localparam int NT0 = 64, DC0 = 16;
    localparam int NT1 = 64, DC1 = 8;
    localparam int NT2 = 4,  DC2 = 1;
    localparam int NT_A [NI] = '{NT0, NT1, NT2};
    localparam int DC_A [NI] = '{DC0, DC1, DC2};

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = '0;

    logic [15:0] o_data  [NI];
    logic [7:0]  o_wa    [NI];
    logic        o_wren  [NI];
    logic [7:0]  o_ra    [NI];
    logic        o_tv    [NI];
    logic        o_tf    [NI];
    logic        o_tl    [NI];
    logic [5:0]  o_coef  [NI];
    logic        o_busy  [NI];
    logic        o_ovr   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fir_tap_sequencer #(.NTAPS(NT0), .DECIM(DC0)) u_dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .ram_data(o_data[0]), .ram_wraddress(o_wa[0]), .ram_wren(o_wren[0]),
        .ram_rdaddress(o_ra[0]), .tap_valid(o_tv[0]), .tap_first(o_tf[0]),
        .tap_last(o_tl[0]), .coef_addr(o_coef[0]), .busy(o_busy[0]), .overrun(o_ovr[0]));

    fir_tap_sequencer #(.NTAPS(NT1), .DECIM(DC1)) u_dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .ram_data(o_data[1]), .ram_wraddress(o_wa[1]), .ram_wren(o_wren[1]),
        .ram_rdaddress(o_ra[1]), .tap_valid(o_tv[1]), .tap_first(o_tf[1]),
        .tap_last(o_tl[1]), .coef_addr(o_coef[1]), .busy(o_busy[1]), .overrun(o_ovr[1]));

    fir_tap_sequencer #(.NTAPS(NT2), .DECIM(DC2)) u_dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .ram_data(o_data[2]), .ram_wraddress(o_wa[2]), .ram_wren(o_wren[2]),
        .ram_rdaddress(o_ra[2]), .tap_valid(o_tv[2]), .tap_first(o_tf[2]),
        .tap_last(o_tl[2]), .coef_addr(o_coef[2]), .busy(o_busy[2]), .overrun(o_ovr[2]));

    // Reference model: a burst is described by its age (cycles since its first
    // read); ages 0..G-1 are reads, age G is the flush cycle, -1 means no burst.
    int m_wptr [NI], m_phase [NI], m_trig [NI], m_tbase [NI];
    int m_age  [NI], m_base  [NI], m_rdh  [NI], m_prevk [NI];
    int m_pend [NI], m_pbase [NI], m_ovr  [NI];
    int e_wren [NI], e_wdata [NI], e_waddr [NI];
    bit model_ok = 1'b0;

    function automatic int groups(input int i);
        return NT_A[i] / 4;
    endfunction

    function automatic int k_now(input int i);
        if (m_age[i] >= 0 && m_age[i] < groups(i)) return m_age[i];
        return -1;
    endfunction

    function automatic int rd_now(input int i);
        int k;
        k = k_now(i);
        if (k >= 0) return (m_base[i] + 4 * k) % 256;
        return m_rdh[i];
    endfunction

    function automatic int busy_now(input int i);
        return (m_age[i] >= 0) ? 1 : 0;
    endfunction

    task automatic model_reset(input int i);
        m_wptr[i] = 0;  m_phase[i] = 0; m_trig[i] = 0;  m_tbase[i] = 0;
        m_age[i]  = -1; m_base[i]  = 0; m_rdh[i]  = 0;  m_prevk[i] = -1;
        m_pend[i] = 0;  m_pbase[i] = 0; m_ovr[i]  = 0;
        e_wren[i] = 0;  e_wdata[i] = 0; e_waddr[i] = 0;
    endtask

    task automatic model_step(input int i, input int v, input int d);
        int g, sb;
        bit can_start, start;
        g  = groups(i);
        sb = 0;
        start = 1'b0;
        m_rdh[i]   = rd_now(i);
        m_prevk[i] = k_now(i);
        can_start  = (m_age[i] < 0) || (m_age[i] == g);
        if (can_start && (m_pend[i] != 0 || m_trig[i] != 0)) begin
            start = 1'b1;
            if (m_pend[i] != 0) begin
                sb        = m_pbase[i];
                m_pend[i] = m_trig[i];
                m_pbase[i] = m_tbase[i];
            end else begin
                sb = m_tbase[i];
            end
        end else if (m_trig[i] != 0) begin
            if (m_pend[i] != 0) m_ovr[i] = 1;
            else begin
                m_pend[i]  = 1;
                m_pbase[i] = m_tbase[i];
            end
        end
        if (start) begin
            m_age[i]  = 0;
            m_base[i] = sb;
        end else if (m_age[i] >= 0) begin
            m_age[i]++;
            if (m_age[i] > g) m_age[i] = -1;
        end
        m_trig[i] = 0;
        e_wren[i] = v;
        if (v != 0) begin
            e_wdata[i] = d;
            e_waddr[i] = m_wptr[i];
            if (m_phase[i] == DC_A[i] - 1) begin
                m_trig[i]  = 1;
                m_tbase[i] = (m_wptr[i] - NT_A[i] + 1 + 256) % 256;
                m_phase[i] = 0;
            end else begin
                m_phase[i]++;
            end
            m_wptr[i] = (m_wptr[i] + 1) % 256;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) model_reset(i);
            model_ok = 1'b1;
        end else begin
            for (int i = 0; i < NI; i++) model_step(i, int'(in_valid), int'(in_data));
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (model_ok) begin
            for (int i = 0; i < NI; i++) begin
                chk("ram_wren", i, int'(o_wren[i]), e_wren[i]);
                if (e_wren[i] != 0) begin
                    chk("ram_data", i, int'(o_data[i]), e_wdata[i]);
                    chk("ram_wraddress", i, int'(o_wa[i]), e_waddr[i]);
                end
                chk("ram_rdaddress", i, int'(o_ra[i]), rd_now(i));
                chk("tap_valid", i, int'(o_tv[i]), (m_prevk[i] >= 0) ? 1 : 0);
                if (m_prevk[i] >= 0) begin
                    chk("tap_first", i, int'(o_tf[i]), (m_prevk[i] == 0) ? 1 : 0);
                    chk("tap_last", i, int'(o_tl[i]), (m_prevk[i] == groups(i) - 1) ? 1 : 0);
                    chk("coef_addr", i, int'(o_coef[i]), m_prevk[i]);
                end
                chk("busy", i, int'(o_busy[i]), busy_now(i));
                chk("overrun", i, int'(o_ovr[i]), m_ovr[i]);
            end
        end
    end

    // After this returns, DUT outputs reflect the previous call's inputs.
    task automatic step(input bit v, input logic [15:0] d);
        @(negedge clock);
        #1;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int tv_count;
        int pct [4];
        pct = '{15, 45, 75, 100};

        repeat (3) @(negedge clock);
        #1;
        chk("reset_rdaddress", 0, int'(o_ra[0]), 0);
        chk("reset_busy", 0, int'(o_busy[0]), 0);
        reset = 1'b0;

        // Three samples after reset land at addresses 0,1,2.
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0002);
        chk("lit_wren0", 0, int'(o_wren[0]), 1);
        chk("lit_waddr0", 0, int'(o_wa[0]), 0);
        chk("lit_wdata0", 0, int'(o_data[0]), 1);
        step(1'b1, 16'h0003);
        chk("lit_waddr1", 0, int'(o_wa[0]), 1);
        chk("lit_wdata1", 0, int'(o_data[0]), 2);
        chk("lit_c_base", 2, int'(o_ra[2]), 253);
        chk("lit_c_busy", 2, int'(o_busy[2]), 1);
        step(1'b0, 16'h0000);
        chk("lit_waddr2", 0, int'(o_wa[0]), 2);
        chk("lit_wdata2", 0, int'(o_data[0]), 3);
        chk("lit_c_tap_valid", 2, int'(o_tv[2]), 1);
        chk("lit_c_tap_first", 2, int'(o_tf[2]), 1);
        chk("lit_c_tap_last", 2, int'(o_tl[2]), 1);
        chk("lit_c_coef", 2, int'(o_coef[2]), 0);
        step(1'b0, 16'h0000);
        chk("lit_wren_idle", 0, int'(o_wren[0]), 0);

        // Samples 4..16 complete the first decimation period of instance A.
        for (int v = 4; v <= 16; v++) step(1'b1, 16'(v));
        step(1'b0, 16'h0000);
        chk("lit_trig_waddr", 0, int'(o_wa[0]), 15);
        for (int k = 0; k <= 16; k++) begin
            step(1'b0, 16'h0000);
            if (k < 16) begin
                chk("lit_burst_rd", 0, int'(o_ra[0]), (208 + 4 * k) % 256);
            end else begin
                chk("lit_flush_hold", 0, int'(o_ra[0]), 12);
            end
            chk("lit_burst_busy", 0, int'(o_busy[0]), 1);
            if (k >= 1) begin
                chk("lit_burst_coef", 0, int'(o_coef[0]), k - 1);
                chk("lit_burst_first", 0, int'(o_tf[0]), (k == 1) ? 1 : 0);
                chk("lit_burst_last", 0, int'(o_tl[0]), (k == 16) ? 1 : 0);
            end
        end
        repeat (20) step(1'b0, 16'h0000);

        // 300 continuous samples: A must never overrun, B (DECIM=8) must.
        do_reset();
        for (int n = 0; n < 300; n++) step(1'b1, 16'($urandom));
        step(1'b0, 16'h0000);
        chk("lit_wrap_waddr", 0, int'(o_wa[0]), 43);
        repeat (40) step(1'b0, 16'h0000);
        chk("lit_a_overrun", 0, int'(o_ovr[0]), 0);
        chk("lit_b_overrun", 1, int'(o_ovr[1]), 1);
        chk("lit_a_drained", 0, int'(o_busy[0]), 0);

        // Reset in the middle of a burst, at read group 7.
        do_reset();
        for (int n = 0; n < 200 && m_age[0] != 7; n++) step(1'b1, 16'($urandom));
        chk("group7_reached", 0, (m_age[0] == 7) ? 1 : 0, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_rdaddress", 0, int'(o_ra[0]), 0);
        chk("rst_busy", 0, int'(o_busy[0]), 0);
        chk("rst_wren", 0, int'(o_wren[0]), 0);
        chk("rst_waddr", 0, int'(o_wa[0]), 0);
        chk("rst_wdata", 0, int'(o_data[0]), 0);
        chk("rst_tap_valid", 0, int'(o_tv[0]), 0);
        chk("rst_coef", 0, int'(o_coef[0]), 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        tv_count = 0;
        for (int n = 0; n < 10; n++) begin
            step(1'b0, 16'h0000);
            tv_count += int'(o_tv[0]);
        end
        chk("rst_no_taps", 0, tv_count, 0);
        step(1'b1, 16'h1234);
        step(1'b0, 16'h0000);
        chk("rst_next_waddr", 0, int'(o_wa[0]), 0);
        chk("rst_next_wdata", 0, int'(o_data[0]), 16'h1234);

        // Random traffic at several densities, model-checked every cycle.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int n = 0; n < 600; n++)
                step(($urandom_range(99) < pct[s]), 16'($urandom));
            repeat (40) step(1'b0, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
